// File: rtl/pipe_skid_stage_pkg.sv
// Shared types and constants for the pipe_skid_stage writeback stage.
// Holds the payload record at default widths and the stall-counter width.
package pipe_skid_stage_pkg;

  localparam int unsigned STALL_W    = 16;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_RD_W   = 5;

  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  typedef struct packed {
    logic [DEF_RD_W-1:0]   rd;
    logic [DEF_DATA_W-1:0] c;
    logic                  save_to_reg;
  } payload_t;

endpackage

// File: rtl/pipe_skid_stage_entry_reg.sv
// One pipeline slot: a payload plus its valid bit, with clear and load.
// Clear zeroes the payload so an empty slot always presents a bubble.
module pipe_entry_reg #(
  parameter type payload_t = pipe_skid_stage_pkg::payload_t
) (
  input  logic     stg_clk,
  input  logic     reset,
  input  logic     clear,
  input  logic     load,
  input  payload_t d,
  output logic     valid,
  output payload_t q
);

  // NOTE: the payload is reset along with valid because empty slots must read as zero.
  always_ff @(posedge stg_clk) begin
    if (reset || clear) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Writeback pipeline stage with optional skid entry, flush, hold and a
// saturating stall counter.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter bit SKID   = 1'b1
) (
  input  logic               stg_clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RD_W-1:0]    rd,
  input  logic [DATA_W-1:0]  c,
  input  logic               save_to_reg,
  input  logic               stg_x,
  input  logic               stg_ena,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RD_W-1:0]    rd_out,
  output logic [DATA_W-1:0]  c_out,
  output logic               save_to_reg_out,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] c;
    logic              save_to_reg;
  } entry_t;

  entry_t in_ent, main_d, main_q, skid_q;
  logic   main_valid, skid_valid;
  logic   accept, fire;
  logic   main_load, main_clear;

  assign in_ent = '{rd: rd, c: c, save_to_reg: save_to_reg};
  assign accept = in_valid && in_ready;
  assign fire   = main_valid && out_ready && !stg_ena;

  // A waiting skid entry always refills main before a new input can.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    main_load = 1'b0;
    main_d    = in_ent;
    if (skid_valid && fire) begin
      main_load = 1'b1;
      main_d    = skid_q;
    end else if (accept && (!main_valid || fire)) begin
      main_load = 1'b1;
    end
    main_clear = stg_x || (fire && !main_load);
  end

  pipe_entry_reg #(.payload_t(entry_t)) u_main (
    .stg_clk (stg_clk),
    .reset   (reset),
    .clear   (main_clear),
    .load    (main_load),
    .d       (main_d),
    .valid   (main_valid),
    .q       (main_q)
  );

  if (SKID) begin : g_skid
    logic skid_load, skid_clear;

    // in_ready is driven only by the skid flop, cutting the out_ready path.
    assign in_ready   = !skid_valid;
    assign skid_load  = accept && main_valid && !fire;
    assign skid_clear = stg_x || (skid_valid && fire);

    pipe_entry_reg #(.payload_t(entry_t)) u_skid (
      .stg_clk (stg_clk),
      .reset   (reset),
      .clear   (skid_clear),
      .load    (skid_load),
      .d       (in_ent),
      .valid   (skid_valid),
      .q       (skid_q)
    );
  end else begin : g_no_skid
    assign in_ready   = !main_valid || fire;
    assign skid_valid = 1'b0;
    assign skid_q     = '0;
  end

  assign out_valid       = main_valid;
  assign rd_out          = main_q.rd;
  assign c_out           = main_q.c;
  assign save_to_reg_out = main_q.save_to_reg;

  // Flush does not touch the counter; only reset clears it.
  always_ff @(posedge stg_clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (main_valid && !fire && (stall_cnt != STALL_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: SKID=1 and SKID=0 builds side by
// side, table vectors, directed corner sequences and a queue reference model.
module tb_pipe_skid_stage;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] c;
    logic        s;
  } ent_t;

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic [31:0] c;
    logic        s;
    logic        x;
    logic        ena;
    logic        ordy;
    logic        e_ov;
    logic [4:0]  e_rd;
    logic [31:0] e_c;
    logic        e_s;
    logic        e_ir;
    logic        chk0;
  } vec_t;

  localparam int NVEC = 20;
  localparam logic [63:0] RESET_VEC = {8'b0, 1'b0, 5'b0, 32'b0, 1'b0, 1'b1, 16'b0};

  logic        stg_clk = 1'b0;
  logic        reset, in_valid, save, stg_x, stg_ena, out_ready;
  logic [4:0]  rd;
  logic [31:0] c;

  logic        ir1, ov1, so1, ir0, ov0, so0;
  logic [4:0]  rdo1, rdo0;
  logic [31:0] co1, co0;
  logic [15:0] cnt1, cnt0;

  int n_cmp = 0;
  int n_bad = 0;

  ent_t        mdl_e   [2][2];
  int          mdl_n   [2];
  logic [15:0] mdl_cnt [2];
  vec_t        tbl [NVEC];

  always #5 stg_clk = ~stg_clk;

  pipe_skid_stage #(.DATA_W(32), .RD_W(5), .SKID(1'b1)) dut1 (
    .stg_clk(stg_clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1),
    .rd(rd), .c(c), .save_to_reg(save), .stg_x(stg_x), .stg_ena(stg_ena),
    .out_valid(ov1), .out_ready(out_ready), .rd_out(rdo1), .c_out(co1),
    .save_to_reg_out(so1), .stall_cnt(cnt1)
  );

  pipe_skid_stage #(.DATA_W(32), .RD_W(5), .SKID(1'b0)) dut0 (
    .stg_clk(stg_clk), .reset(reset), .in_valid(in_valid), .in_ready(ir0),
    .rd(rd), .c(c), .save_to_reg(save), .stg_x(stg_x), .stg_ena(stg_ena),
    .out_valid(ov0), .out_ready(out_ready), .rd_out(rdo0), .c_out(co0),
    .save_to_reg_out(so0), .stall_cnt(cnt0)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] dut_vec(input int k);
    if (k == 1) return {8'b0, ov1, rdo1, co1, so1, ir1, cnt1};
    return {8'b0, ov0, rdo0, co0, so0, ir0, cnt0};
  endfunction

  // Reference: a FIFO of at most 2 (skid) or 1 (no skid) entries.
  function automatic logic [63:0] mdl_vec(input int k);
    ent_t h    = (mdl_n[k] > 0) ? mdl_e[k][0] : '0;
    logic ov   = (mdl_n[k] > 0);
    logic fire = ov && out_ready && !stg_ena;
    logic ir   = (k == 1) ? (mdl_n[k] < 2) : (!ov || fire);
    return {8'b0, ov, h.rd, h.c, h.s, ir, mdl_cnt[k]};
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic ov, fire, ir;
      ov   = (mdl_n[k] > 0);
      fire = ov && out_ready && !stg_ena;
      ir   = (k == 1) ? (mdl_n[k] < 2) : (!ov || fire);
      if (reset) begin
        mdl_n[k]   = 0;
        mdl_cnt[k] = 16'd0;
      end else begin
        if (ov && !fire && mdl_cnt[k] != 16'hFFFF) mdl_cnt[k] = mdl_cnt[k] + 16'd1;
        if (stg_x) begin
          mdl_n[k] = 0;
        end else begin
          if (fire) begin
            mdl_e[k][0] = mdl_e[k][1];
            mdl_n[k]--;
          end
          if (in_valid && ir) begin
            mdl_e[k][mdl_n[k]] = '{rd, c, save};
            mdl_n[k]++;
          end
        end
      end
    end
  endtask

  task automatic set_in(input logic v, input logic [4:0] r, input logic [31:0] cv,
                        input logic s, input logic x, input logic ena,
                        input logic ordy, input logic rst);
    in_valid = v; rd = r; c = cv; save = s;
    stg_x = x; stg_ena = ena; out_ready = ordy; reset = rst;
    #1;
  endtask

  task automatic finish_cycle();
    for (int k = 0; k < 2; k++)
      check($sformatf("model k%0d t=%0t", k, $time), dut_vec(k), mdl_vec(k));
    model_step();
    @(negedge stg_clk);
  endtask

  task automatic cycle(input logic v, input logic [4:0] r, input logic [31:0] cv,
                       input logic s, input logic x, input logic ena,
                       input logic ordy, input logic rst);
    set_in(v, r, cv, s, x, ena, ordy, rst);
    finish_cycle();
  endtask

  function automatic vec_t mk(input logic v, input logic [4:0] r, input logic [31:0] cv,
                              input logic s, input logic x, input logic ena, input logic ordy,
                              input logic eov, input logic [4:0] erd, input logic [31:0] ec,
                              input logic es, input logic eir, input logic chk0);
    vec_t t;
    t.v = v; t.rd = r; t.c = cv; t.s = s; t.x = x; t.ena = ena; t.ordy = ordy;
    t.e_ov = eov; t.e_rd = erd; t.e_c = ec; t.e_s = es; t.e_ir = eir; t.chk0 = chk0;
    return t;
  endfunction

  initial begin
    // Expected values are the outputs seen in the row's own cycle, before its edge.
    tbl[0]  = mk(1, 1, 32'h10, 1, 0, 0, 1,  0, 0, 32'h00, 0, 1, 1);
    tbl[1]  = mk(1, 2, 32'h20, 0, 0, 0, 1,  1, 1, 32'h10, 1, 1, 1);
    tbl[2]  = mk(1, 3, 32'h30, 1, 0, 0, 1,  1, 2, 32'h20, 0, 1, 1);
    tbl[3]  = mk(1, 4, 32'h40, 0, 0, 0, 1,  1, 3, 32'h30, 1, 1, 1);
    tbl[4]  = mk(0, 0, 32'h00, 0, 0, 0, 1,  1, 4, 32'h40, 0, 1, 1);
    tbl[5]  = mk(0, 0, 32'h00, 0, 0, 0, 1,  0, 0, 32'h00, 0, 1, 1);
    tbl[6]  = mk(1, 7, 32'hAA, 0, 0, 0, 1,  0, 0, 32'h00, 0, 1, 1);
    tbl[7]  = mk(1, 8, 32'hBB, 0, 0, 0, 0,  1, 7, 32'hAA, 0, 1, 0);
    tbl[8]  = mk(0, 0, 32'h00, 0, 0, 0, 0,  1, 7, 32'hAA, 0, 0, 0);
    tbl[9]  = mk(0, 0, 32'h00, 0, 0, 0, 1,  1, 7, 32'hAA, 0, 0, 0);
    tbl[10] = mk(0, 0, 32'h00, 0, 0, 0, 1,  1, 8, 32'hBB, 0, 1, 0);
    tbl[11] = mk(0, 0, 32'h00, 0, 0, 0, 1,  0, 0, 32'h00, 0, 1, 0);
    tbl[12] = mk(1, 1, 32'h01, 1, 0, 0, 0,  0, 0, 32'h00, 0, 1, 0);
    tbl[13] = mk(1, 2, 32'h02, 0, 0, 0, 0,  1, 1, 32'h01, 1, 1, 0);
    tbl[14] = mk(1, 3, 32'h03, 0, 1, 0, 0,  1, 1, 32'h01, 1, 0, 0);
    tbl[15] = mk(0, 0, 32'h00, 0, 0, 0, 1,  0, 0, 32'h00, 0, 1, 0);
    tbl[16] = mk(1, 5, 32'h55, 1, 1, 0, 1,  0, 0, 32'h00, 0, 1, 0);
    tbl[17] = mk(1, 6, 32'h66, 0, 0, 0, 1,  0, 0, 32'h00, 0, 1, 0);
    tbl[18] = mk(0, 0, 32'h00, 0, 1, 1, 1,  1, 6, 32'h66, 0, 1, 0);
    tbl[19] = mk(0, 0, 32'h00, 0, 0, 0, 1,  0, 0, 32'h00, 0, 1, 0);

    for (int k = 0; k < 2; k++) begin
      mdl_n[k]   = 0;
      mdl_cnt[k] = 16'd0;
    end

    // Power-up reset: outputs are unknown until the first edge, so no checks yet.
    in_valid = 0; rd = '0; c = '0; save = 0; stg_x = 0; stg_ena = 0; out_ready = 0;
    reset = 1;
    repeat (2) begin
      model_step();
      @(negedge stg_clk);
    end

    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    check("reset state k1", dut_vec(1), RESET_VEC);
    check("reset state k0", dut_vec(0), RESET_VEC);
    finish_cycle();

    for (int i = 0; i < NVEC; i++) begin
      set_in(tbl[i].v, tbl[i].rd, tbl[i].c, tbl[i].s, tbl[i].x, tbl[i].ena, tbl[i].ordy, 0);
      check($sformatf("vec%0d k1", i), {24'b0, ov1, rdo1, co1, so1, ir1},
            {24'b0, tbl[i].e_ov, tbl[i].e_rd, tbl[i].e_c, tbl[i].e_s, tbl[i].e_ir});
      if (tbl[i].chk0)
        check($sformatf("vec%0d k0", i), {24'b0, ov0, rdo0, co0, so0, ir0},
              {24'b0, tbl[i].e_ov, tbl[i].e_rd, tbl[i].e_c, tbl[i].e_s, tbl[i].e_ir});
      finish_cycle();
    end

    // Hold with a valid entry: five stalled cycles, then long enough to saturate.
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    cycle(1, 9, 32'h99, 1, 0, 1, 1, 0);
    repeat (5) cycle(0, 0, 0, 0, 0, 1, 1, 0);
    set_in(0, 0, 0, 0, 0, 1, 1, 0);
    check("hold5 cnt k1", {48'b0, cnt1}, 64'd5);
    check("hold5 cnt k0", {48'b0, cnt0}, 64'd5);
    check("hold5 out k1", {25'b0, ov1, rdo1, co1, so1}, {25'b0, 1'b1, 5'd9, 32'h99, 1'b1});
    finish_cycle();
    repeat (70000) cycle(0, 0, 0, 0, 0, 1, 1, 0);
    set_in(0, 0, 0, 0, 0, 1, 1, 0);
    check("saturate cnt k1", {48'b0, cnt1}, 64'hFFFF);
    check("saturate cnt k0", {48'b0, cnt0}, 64'hFFFF);
    finish_cycle();
    cycle(0, 0, 0, 0, 0, 0, 1, 0);

    // Reset mid-stream together with flush and an offered input.
    cycle(1, 1, 32'h11, 1, 0, 0, 1, 0);
    cycle(1, 2, 32'h22, 1, 0, 0, 0, 0);
    set_in(1, 3, 32'h33, 1, 1, 0, 0, 1);
    finish_cycle();
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    check("mid reset k1", dut_vec(1), RESET_VEC);
    check("mid reset k0", dut_vec(0), RESET_VEC);
    finish_cycle();

    for (int i = 0; i < 3000; i++)
      cycle(($urandom % 4) != 0, 5'($urandom), $urandom, 1'($urandom),
            ($urandom % 20) == 0, ($urandom % 4) == 0, 1'($urandom),
            ($urandom % 300) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
